// File: rtl/des_cbc_stream_pkg.sv
// Shared types and constants for the DES CBC/ECB streaming wrapper.
package des_cbc_stream_pkg;

   localparam int unsigned BLK_W     = 64;
   localparam int unsigned CNT_W_DEF = 16;

   typedef logic [BLK_W-1:0] block_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/des_cbc_stream_core.sv
// Combinational single-block DES with the CBC xor folded around it.
module des_cbc_stream_core
   import des_cbc_stream_pkg::*;
(
   input  logic [BLK_W-1:0] key,
   input  logic [BLK_W-1:0] plaintext,
   input  logic             encrypt,
   input  logic             cbc,
   input  logic [BLK_W-1:0] iv,
   output logic [BLK_W-1:0] result_c
);

   // Tables use the DES 1-based MSB-first bit numbering.
   localparam int unsigned IP_T [64] = '{
      58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int unsigned FP_T [64] = '{
      40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
      38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
      34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int unsigned E_T [48] = '{
      32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
      16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int unsigned P_T [32] = '{
      16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
      2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
   localparam int unsigned PC1_T [56] = '{
      57,49,41,33,25,17,9,1,  58,50,42,34,26,18,10,2,
      59,51,43,35,27,19,11,3, 60,52,44,36,63,55,47,39,
      31,23,15,7,62,54,46,38, 30,22,14,6,61,53,45,37,
      29,21,13,5,28,20,12,4};
   localparam int unsigned PC2_T [48] = '{
      14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
      41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   localparam int unsigned SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   // Each S-box is 64 nibbles, row-major, row 0 column 0 in the top nibble.
   localparam logic [255:0] SBOX_T [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) r[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
      return r;
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) r[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
      return r;
   endfunction

   function automatic logic [47:0] expand(input logic [31:0] x);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
      return r;
   endfunction

   function automatic logic [31:0] perm_p(input logic [31:0] x);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
      return r;
   endfunction

   function automatic logic [55:0] perm_pc1(input logic [63:0] x);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
      return r;
   endfunction

   function automatic logic [47:0] perm_pc2(input logic [55:0] x);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) r[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
      return r;
   endfunction

   function automatic logic [3:0] sbox_lu(input int n, input logic [5:0] b);
      logic [255:0] t;
      logic [5:0]   ridx;
      t    = SBOX_T[3'(n)];
      ridx = ~{b[5], b[0], b[4:1]};
      return t[{ridx, 2'b00} +: 4];
   endfunction

   function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      x = expand(r) ^ k;
      s = '0;
      for (int n = 0; n < 8; n++) s[5'(28 - 4*n) +: 4] = sbox_lu(n, x[6'(42 - 6*n) +: 6]);
      return perm_p(s);
   endfunction

   function automatic logic [63:0] des_block(input logic [63:0] k, input logic [63:0] d,
                                             input logic enc);
      logic [55:0] cd;
      logic [27:0] c, dd;
      logic [47:0] sk [16];
      logic [63:0] lr;
      logic [31:0] l, r, t;
      cd = perm_pc1(k);
      c  = cd[55:28];
      dd = cd[27:0];
      for (int i = 0; i < 16; i++) begin
         if (SHIFT_T[4'(i)] == 2) begin
            c  = {c[25:0], c[27:26]};
            dd = {dd[25:0], dd[27:26]};
         end else begin
            c  = {c[26:0], c[27]};
            dd = {dd[26:0], dd[27]};
         end
         sk[4'(i)] = perm_pc2({c, dd});
      end
      lr = perm_ip(d);
      l  = lr[63:32];
      r  = lr[31:0];
      // Decryption is the same network with the subkeys reversed.
      for (int i = 0; i < 16; i++) begin
         t = r;
         r = l ^ feistel(r, enc ? sk[4'(i)] : sk[4'(15 - i)]);
         l = t;
      end
      return perm_fp({r, l});
   endfunction

   logic [BLK_W-1:0] pre_c;
   logic [BLK_W-1:0] raw_c;

   always_comb begin
      pre_c    = (encrypt && cbc) ? (plaintext ^ iv) : plaintext;
      raw_c    = des_block(key, pre_c, encrypt);
      result_c = (!encrypt && cbc) ? (raw_c ^ iv) : raw_c;
   end

endmodule

// File: rtl/des_cbc_stream.sv
// Streaming DES wrapper: latches key/iv/mode on start, one block per cycle, CBC chaining.
module des_cbc_stream
   import des_cbc_stream_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BLK_W-1:0] key_in,
   input  logic [BLK_W-1:0] iv_in,
   input  logic             encrypt_in,
   input  logic             cbc_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] blk_count
);

   state_t           state_q, state_d;
   block_t           key_q, key_d;
   block_t           chain_q, chain_d;
   block_t           out_data_q, out_data_d;
   logic             encrypt_q, encrypt_d;
   logic             cbc_q, cbc_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] blk_count_q, blk_count_d;
   block_t           core_res_c;
   logic             accept_c;

   des_cbc_stream_core u_core (
      .key       (key_q),
      .plaintext (in_data),
      .encrypt   (encrypt_q),
      .cbc       (cbc_q),
      .iv        (chain_q),
      .result_c  (core_res_c)
   );

   // Accept only when the single result slot is free or being drained this cycle.
   assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
   assign accept_c = in_valid && in_ready;
   assign done     = (state_q == ST_FLUSH) && out_valid_q && out_ready && out_last_q;

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      chain_d     = chain_q;
      encrypt_d   = encrypt_q;
      cbc_d       = cbc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      blk_count_d = blk_count_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_RUN;
               key_d       = key_in;
               chain_d     = iv_in;
               encrypt_d   = encrypt_in;
               cbc_d       = cbc_in;
               blk_count_d = '0;
            end
         end
         ST_RUN: begin
            if (accept_c && in_last) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (accept_c) begin
         out_data_d  = core_res_c;
         out_last_d  = in_last;
         out_valid_d = 1'b1;
         blk_count_d = blk_count_q + CNT_W'(1);
         if (cbc_q) chain_d = encrypt_q ? core_res_c : in_data;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         key_q       <= '0;
         chain_q     <= '0;
         encrypt_q   <= 1'b0;
         cbc_q       <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         blk_count_q <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         chain_q     <= chain_d;
         encrypt_q   <= encrypt_d;
         cbc_q       <= cbc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         blk_count_q <= blk_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign blk_count = blk_count_q;

endmodule

// File: tb/tb_des_cbc_stream.sv
// Directed-vector bench for des_cbc_stream (narrow counter to reach the wrap point quickly).
module tb_des_cbc_stream;
   import des_cbc_stream_pkg::*;

   localparam int unsigned TB_CNT_W = 4;
   localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
   localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
   localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
   localparam logic [63:0] C1 = 64'h85E813540F0AB405;
   localparam logic [63:0] P2 = 64'h84CB563386A179EA;  // P1 ^ C1
   localparam logic [63:0] P3 = 64'h8787878787878787;
   localparam logic [63:0] IVA = 64'hAAAAAAAAAAAAAAAA;

   logic                clk = 1'b0;
   logic                rst_n, start, encrypt_in, cbc_in;
   logic [63:0]         key_in, iv_in, in_data;
   logic                in_valid, in_ready, in_last;
   logic                out_valid, out_ready, out_last, busy, done;
   logic [63:0]         out_data;
   logic [TB_CNT_W-1:0] blk_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   des_cbc_stream #(.CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .iv_in(iv_in),
      .encrypt_in(encrypt_in), .cbc_in(cbc_in), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
      .blk_count(blk_count)
   );

   task automatic do_start(input logic [63:0] k, input logic [63:0] iv,
                           input logic enc, input logic cb);
      @(negedge clk);
      start = 1'b1; key_in = k; iv_in = iv; encrypt_in = enc; cbc_in = cb;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offers one block, waits (bounded) for acceptance, returns the output seen one cycle later.
   task automatic xfer(input logic [63:0] d, input logic last, output logic acc,
                       output logic ov, output logic [63:0] od, output logic ol,
                       output logic dn);
      int n;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_last = last; out_ready = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 8) begin
         #1;
         if (in_ready) acc = 1'b1;
         else @(negedge clk);
         n++;
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      ov = out_valid; od = out_data; ol = out_last; dn = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      key_in = K1; iv_in = P1; encrypt_in = 1'b1; cbc_in = 1'b1;
      in_data = P1; in_last = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
      checks++; if (out_data !== 64'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (blk_count !== 4'd0) begin failures++; $display("FAIL rst_blk_count got=%0d exp=0", blk_count); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      rst_n = 1'b1;
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
      in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready got=%b exp=0", in_ready); end
      in_valid = 1'b0;
   endtask

   task automatic test_ecb_single();
      logic acc, ov, ol, dn;
      logic [63:0] od;
      do_start(K1, 64'h0, 1'b1, 1'b0);
      #1;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ecb_busy got=%b exp=1", busy); end
      checks++; if (blk_count !== 4'd0) begin failures++; $display("FAIL ecb_cnt0 got=%0d exp=0", blk_count); end
      xfer(P1, 1'b1, acc, ov, od, ol, dn);
      checks++; if (acc !== 1'b1) begin failures++; $display("FAIL ecb_accept got=%b exp=1", acc); end
      checks++; if (ov !== 1'b1) begin failures++; $display("FAIL ecb_out_valid got=%b exp=1", ov); end
      checks++; if (od !== C1) begin failures++; $display("FAIL ecb_enc_data got=%h exp=%h", od, C1); end
      checks++; if (ol !== 1'b1) begin failures++; $display("FAIL ecb_out_last got=%b exp=1", ol); end
      checks++; if (dn !== 1'b1) begin failures++; $display("FAIL ecb_done got=%b exp=1", dn); end
      checks++; if (blk_count !== 4'd1) begin failures++; $display("FAIL ecb_cnt got=%0d exp=1", blk_count); end
      @(negedge clk); out_ready = 1'b0; #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ecb_idle_busy got=%b exp=0", busy); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ecb_drained got=%b exp=0", out_valid); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL ecb_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_ecb_decrypt();
      logic acc, ov, ol, dn;
      logic [63:0] od;
      do_start(K1, 64'h0, 1'b0, 1'b0);
      xfer(C1, 1'b1, acc, ov, od, ol, dn);
      checks++; if (od !== P1) begin failures++; $display("FAIL ecb_dec_data got=%h exp=%h", od, P1); end
      checks++; if (dn !== 1'b1) begin failures++; $display("FAIL ecb_dec_done got=%b exp=1", dn); end
      do_start(K2, 64'h0, 1'b1, 1'b0);
      xfer(P3, 1'b1, acc, ov, od, ol, dn);
      checks++; if (od !== 64'h0) begin failures++; $display("FAIL k2_enc_data got=%h exp=0", od); end
      do_start(K2, 64'h0, 1'b0, 1'b0);
      xfer(64'h0, 1'b1, acc, ov, od, ol, dn);
      checks++; if (od !== P3) begin failures++; $display("FAIL k2_dec_data got=%h exp=%h", od, P3); end
   endtask

   task automatic test_cbc();
      logic acc, ov, ol, dn;
      logic [63:0] od;
      logic [63:0] pt [3];
      logic [63:0] ct [3];
      pt[0] = P1; pt[1] = P2; pt[2] = P2;
      ct[0] = C1; ct[1] = C1; ct[2] = C1;
      do_start(K1, 64'h0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         xfer(pt[i], (i == 2), acc, ov, od, ol, dn);
         checks++; if (od !== ct[i]) begin failures++; $display("FAIL cbc_enc_blk%0d got=%h exp=%h", i, od, ct[i]); end
      end
      checks++; if (dn !== 1'b1) begin failures++; $display("FAIL cbc_enc_done got=%b exp=1", dn); end
      checks++; if (blk_count !== 4'd3) begin failures++; $display("FAIL cbc_enc_cnt got=%0d exp=3", blk_count); end
      do_start(K1, 64'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         xfer(ct[i], (i == 2), acc, ov, od, ol, dn);
         checks++; if (od !== pt[i]) begin failures++; $display("FAIL cbc_dec_blk%0d got=%h exp=%h", i, od, pt[i]); end
         checks++; if (ol !== (i == 2)) begin failures++; $display("FAIL cbc_dec_last%0d got=%b exp=%b", i, ol, (i == 2)); end
      end
   endtask

   task automatic test_backpressure();
      do_start(K1, 64'h0, 1'b0, 1'b1);
      @(negedge clk);
      in_valid = 1'b1; in_data = C1; in_last = 1'b0; out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_first_ready got=%b exp=1", in_ready); end
      @(negedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready c%0d got=%b exp=0", k, in_ready); end
         checks++; if (out_data !== P1 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold c%0d got=%h/%b exp=%h/1", k, out_data, out_valid, P1); end
         checks++; if (blk_count !== 4'd1) begin failures++; $display("FAIL bp_cnt c%0d got=%0d exp=1", k, blk_count); end
         @(negedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      in_data = C1; in_last = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== P2) begin failures++; $display("FAIL bp_blk2 got=%h/%b exp=%h/1", out_data, out_valid, P2); end
      checks++; if (blk_count !== 4'd2) begin failures++; $display("FAIL bp_cnt2 got=%0d exp=2", blk_count); end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      checks++; if (out_data !== P2 || out_last !== 1'b1) begin failures++; $display("FAIL bp_blk3 got=%h/%b exp=%h/1", out_data, out_last, P2); end
      checks++; if (blk_count !== 4'd3) begin failures++; $display("FAIL bp_cnt3 got=%0d exp=3", blk_count); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", done); end
      @(negedge clk); out_ready = 1'b0; #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b exp=0", busy); end
   endtask

   task automatic test_flush_ignore();
      do_start(K1, IVA, 1'b1, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; in_data = P1; in_last = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_data = P3; in_last = 1'b0;
      start = 1'b1; key_in = K2; iv_in = P3; encrypt_in = 1'b0; cbc_in = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fl_in_ready got=%b exp=0", in_ready); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fl_busy got=%b exp=1", busy); end
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++; if (blk_count !== 4'd1) begin failures++; $display("FAIL fl_cnt got=%0d exp=1", blk_count); end
      checks++; if (out_data !== C1 || out_valid !== 1'b1) begin failures++; $display("FAIL fl_out got=%h/%b exp=%h/1", out_data, out_valid, C1); end
      checks++; if (dut.key_q !== K1) begin failures++; $display("FAIL fl_key got=%h exp=%h", dut.key_q, K1); end
      checks++; if (dut.chain_q !== IVA) begin failures++; $display("FAIL fl_chain got=%h exp=%h", dut.chain_q, IVA); end
      checks++; if (dut.encrypt_q !== 1'b1 || dut.cbc_q !== 1'b0) begin failures++; $display("FAIL fl_mode got=%b%b exp=10", dut.encrypt_q, dut.cbc_q); end
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL fl_done got=%b exp=1", done); end
      @(negedge clk); out_ready = 1'b0; #1;
      checks++; if (busy !== 1'b0 || blk_count !== 4'd1) begin failures++; $display("FAIL fl_end got=%b/%0d exp=0/1", busy, blk_count); end
   endtask

   task automatic test_reset_mid();
      logic acc, ov, ol, dn;
      logic [63:0] od;
      do_start(K1, 64'h0, 1'b1, 1'b1);
      @(negedge clk);
      in_valid = 1'b1; in_data = P1; in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_valid got=%b exp=1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin failures++; $display("FAIL rm_out got=%h/%b exp=0/0", out_data, out_valid); end
      checks++; if (busy !== 1'b0 || blk_count !== 4'd0) begin failures++; $display("FAIL rm_state got=%b/%0d exp=0/0", busy, blk_count); end
      checks++; if (dut.chain_q !== 64'h0) begin failures++; $display("FAIL rm_chain got=%h exp=0", dut.chain_q); end
      @(negedge clk);
      rst_n = 1'b1;
      do_start(K1, P1, 1'b1, 1'b1);
      xfer(64'h0, 1'b1, acc, ov, od, ol, dn);
      checks++; if (od !== C1) begin failures++; $display("FAIL rm_new_iv got=%h exp=%h", od, C1); end
      checks++; if (dn !== 1'b1) begin failures++; $display("FAIL rm_done got=%b exp=1", dn); end
   endtask

   task automatic test_wrap();
      logic acc, ov, ol, dn;
      logic [63:0] od;
      int naccept;
      naccept = 0;
      do_start(K1, 64'h0, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) begin
         xfer(P1, 1'b0, acc, ov, od, ol, dn);
         if (acc) naccept++;
      end
      checks++; if (naccept != 16) begin failures++; $display("FAIL wrap_accepts got=%0d exp=16", naccept); end
      checks++; if (blk_count !== 4'd0) begin failures++; $display("FAIL wrap_cnt got=%0d exp=0", blk_count); end
      checks++; if (od !== C1 || busy !== 1'b1) begin failures++; $display("FAIL wrap_data got=%h/%b exp=%h/1", od, busy, C1); end
      xfer(P1, 1'b1, acc, ov, od, ol, dn);
      checks++; if (blk_count !== 4'd1 || dn !== 1'b1) begin failures++; $display("FAIL wrap_after got=%0d/%b exp=1/1", blk_count, dn); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ecb_single();
      test_ecb_decrypt();
      test_cbc();
      test_backpressure();
      test_flush_ignore();
      test_reset_mid();
      test_wrap();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
